tff_down_counter: RTL and testbench

Synchronous, loadable down-counter built from T flip-flops. It is the count-down counterpart to the lab's ripple up-counter. It counts a loaded value down to zero on enabled clock edges and signals terminal count with a one-cycle borrow pulse. It then either stops with `done` held or reloads the value and continues. It serves as the timer/divider block for the lab sequential examples.

---
 rtl/counter_pkg.sv | 14 +
 rtl/t_flip_flop_ld.sv | 24 ++
 rtl/tff_down_counter.sv | 113 +++++++++++
 tb/tb_tff_down_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the T-flip-flop down-counter block.
// Holds the FSM state encoding and the default counter width.
// No logic lives here; it is imported by the counter top level.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/t_flip_flop_ld.sv
// Single T flip-flop with a synchronous parallel-load input and async reset.
// Latency: q updates on the rising edge after t/ld are presented.
// Backpressure: none; ld overrides t, rst overrides everything.
module t_flip_flop_ld (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    // Load takes priority over toggle so the counter can be preset cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_down_counter.sv
// Loadable down-counter built from T flip-flops with borrow pulse and reload.
// Latency: load visible on q one edge later; borrow one edge after terminal count.
// Backpressure: en gates counting; load always wins over en and terminal count.
module tff_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_outer,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] par_dat;
    logic             count_step;
    logic             at_zero;
    logic             term_cnt;
    logic             par_ld;

    // An enabled RUN cycle without a load either decrements or hits terminal count.
    assign at_zero    = (q == '0);
    assign count_step = (state == ST_RUN) && en && !load;
    assign term_cnt   = count_step && at_zero;

    // Load and reload share the parallel-load path; zero never toggles, so no wrap.
    assign par_ld  = load || (term_cnt && auto_reload);
    assign par_dat = load ? load_val : reload_val;

    // Toggle-enable chain: bit i flips when every lower bit is already zero.
    always_comb begin
        toggle    = '0;
        toggle[0] = count_step && !at_zero;
        for (int i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] && !q[i-1];
        end
    end

    // One T flip-flop per count bit; all bits switch on the same edge.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        t_flip_flop_ld u_bit (
            .clk (clk),
            .rst (reset_outer),
            .t   (toggle[g]),
            .ld  (par_ld),
            .d   (par_dat[g]),
            .q   (q[g])
        );
    end

    // Reload register remembers the most recent load value.
    always_ff @(posedge clk or posedge reset_outer) begin
        if (reset_outer) begin
            reload_val <= '0;
        end else if (load) begin
            reload_val <= load_val;
        end
    end

    // Borrow is a registered single-cycle pulse following the terminal-count edge.
    always_ff @(posedge clk or posedge reset_outer) begin
        if (reset_outer) begin
            borrow <= 1'b0;
        end else begin
            borrow <= term_cnt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset_outer) begin
        if (reset_outer) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: load always enters RUN; terminal count without reload stops.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (load) begin
                    state_nxt = ST_RUN;
                end else if (term_cnt && !auto_reload) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (load) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status flags decode directly from the state flops, so they are glitch-free.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_tff_down_counter.sv
module tb_tff_down_counter;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic         borrow;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk;
    logic         reset_outer;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         borrow;
    logic         busy;
    logic         done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: plain integers, mode 0=idle 1=run 2=done
    int m_q      = 0;
    int m_reload = 0;
    int m_mode   = 0;
    int m_borrow = 0;

    tff_down_counter #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_outer (reset_outer),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .borrow      (borrow),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    endtask

    task automatic model_reset();
        m_q = 0; m_reload = 0; m_mode = 0; m_borrow = 0;
    endtask

    task automatic model_edge(input bit l, input int lv, input bit e, input bit ar);
        m_borrow = 0;
        if (l) begin
            m_q = lv; m_reload = lv; m_mode = 1;
        end else if (m_mode == 1 && e) begin
            if (m_q > 0) begin
                m_q = m_q - 1;
            end else begin
                m_borrow = 1;
                if (ar) m_q = m_reload;
                else    m_mode = 2;
            end
        end
    endtask

    task automatic step(input bit l, input int lv, input bit e, input bit ar);
        exp_t x;
        @(negedge clk);
        load = l; load_val = W'(lv); en = e; auto_reload = ar;
        @(posedge clk);
        model_edge(l, lv, e, ar);
        x.q = W'(m_q); x.borrow = (m_borrow != 0);
        x.busy = (m_mode == 1); x.done = (m_mode == 2);
        exp_q.push_back(x);
    endtask

    // Monitor: every edge the DUT presents a new count; compare against the queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q",      int'(q),      int'(e.q));
                chk("borrow", int'(borrow), int'(e.borrow));
                chk("busy",   int'(busy),   int'(e.busy));
                chk("done",   int'(done),   int'(e.done));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_q"},      int'(q),      0);
        chk({tag, "_borrow"}, int'(borrow), 0);
        chk({tag, "_busy"},   int'(busy),   0);
        chk({tag, "_done"},   int'(done),   0);
    endtask

    initial begin
        reset_outer = 1'b1;
        load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_outer = 1'b0;
        model_reset();

        // IDLE ignores en
        repeat (2) step(0, 0, 1, 1);

        // Count-down stop from 5
        step(1, 5, 0, 0);
        repeat (6) step(0, 0, 1, 0);
        repeat (5) step(0, 0, 1, 0);

        // Auto-reload of 3 over 12 enabled edges
        step(1, 3, 0, 1);
        repeat (12) step(0, 0, 1, 1);

        // Gated enable
        step(1, 2, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 1, 0);
        step(0, 0, 0, 0); step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Load priority at q=4, then reload of 7
        step(1, 6, 0, 1);
        step(0, 0, 1, 1); step(0, 0, 1, 1);
        step(1, 7, 1, 1);
        repeat (10) step(0, 0, 1, 1);

        // Reset mid-operation
        step(1, 9, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        #3;
        reset_outer = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        reset_outer = 1'b0;
        model_reset();
        repeat (3) step(0, 0, 1, 0);

        // Boundaries: all ones, zero load, load on terminal count
        step(1, 15, 0, 0);
        repeat (17) step(0, 0, 1, 0);
        step(1, 0, 0, 1);
        repeat (3) step(0, 0, 1, 1);
        step(1, 0, 0, 0);
        step(1, 2, 1, 0);
        repeat (4) step(0, 0, 1, 0);

        // Randomized traffic
        repeat (400) begin
            bit l;
            l = ($urandom_range(0, 9) == 0);
            step(l, $urandom_range(0, 15), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0);
        end

        // Drain the scoreboard within a bounded number of cycles
        #2;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
